median_window_buffer: RTL
=========================

// Module: median_window_buffer
// PURPOSE
//  Sliding 5-sample window in front of the radar noise-reducer median core.
//  Accepts a signed sample stream over valid/ready and keeps the newest 5 samples.
//  Presents the window to a Median_Calculator instance and registers the median
//  onto a valid/ready output.
//  Frame boundaries (in_last) and flush clear the window so medians never mix radar frames.
// PARAMETERS
//  DATA_W  32  sample width, 2..32
//              sign-extended to 32 b into the median core; result truncated back to DATA_W
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-high reset
//  flush       in   1       synchronous window clear; has priority over a sample
//  in_valid    in   1       input sample valid
//  in_ready    out  1       block can accept a sample
//  in_data     in   DATA_W  signed sample
//  in_last     in   1       last sample of a radar frame
//  out_valid   out  1       out_data valid
//  out_ready   in   1       downstream accepts
//  out_data    out  DATA_W  signed median (or raw sample, see CONFIGURATION)
//  out_last    out  1       output belongs to the sample that carried in_last
//  fill_level  out  3       number of samples in the window, 0..5
// BEHAVIOUR
//  - Reset (async, rst=1): all outputs 0; fill_level=0; window regs 0; state EMPTY.
//  - Accept condition: acc = in_valid & in_ready.
//    in_ready = ~flush & (~out_valid | out_ready).
//  - On acc: win[4:1] <= win[3:0]; win[0] <= in_data; fill_level saturates at 5.
//  - FSM states:
//    EMPTY: first acc -> FILL.
//    FILL:  acc while fill_level=4 -> FULL.
//    FULL:  stays FULL on acc.
//    Any state, acc with in_last=1: the median is still produced, then fill_level<=0 -> EMPTY.
//    Any state, flush=1: window and fill_level cleared -> EMPTY; pending out_valid is kept.
//  - Output: the median core sees the post-shift window (newest sample included).
//    Output register loads on acc when the window is FULL after the shift.
//    Latency: accept at cycle N -> out_valid=1 at N+1.
//    out_valid holds with stable out_data/out_last until out_ready=1.
//    Load and drain in the same cycle are allowed: full throughput, 1 sample/clk.
//  - Warm-up (fill_level <5 after the shift): no median is emitted (default build).
//  - Frame end: an in_last arriving in warm-up with no output emitted means out_last is dropped.
//    Exception: with MEDIAN_WARMUP_PASS_EN, that sample is emitted raw with out_last=1.
//  - Signed compare throughout. No rounding: the median is always one of the inputs.
// CONFIGURATION
//  MEDIAN_WARMUP_PASS_EN defined:
//    During warm-up each accepted sample is emitted raw on out_data with out_valid.
//    Output count therefore equals input count.
//  MEDIAN_WARMUP_PASS_EN undefined:
//    Warm-up samples produce no output.
//    A frame of L>=5 samples produces L-4 medians.
// STRUCTURE
//  - Package radar_filter_pkg:
//    localparam WIN_LEN=5
//    typedef enum logic [1:0] {EMPTY, FILL, FULL} win_state_t
//    typedef logic signed [31:0] sample_t
//  - Sub-module: Median_Calculator, one instance, combinational, fed by the sign-extended post-shift window.
//  - This file holds the shift register, the FSM, fill_level and the output register.
// TESTING
//  - Reset: rst=1 mid-stream -> all outputs 0, fill_level=0 the same cycle, without waiting for clk.
//  - Warm-up and first median:
//    feed 10,-3,7,100,2 with out_ready=1 -> no output for the first 4;
//    then out_data=7 one cycle after the 5th sample.
//  - Sliding window: continue with 8 -> 7, then -50 -> 7, then 6 -> 6.
//    One output per clk when in_valid=1 continuously.
//  - Back-pressure: hold out_ready=0 for 3 clks -> in_ready=0;
//    out_data stable; no sample lost or duplicated after release.
//  - Frame end: last of 6 samples has in_last=1 -> out_last=1 on its median.
//    Next frame's first 4 samples emit nothing.
//  - Flush with in_valid=1 in the same cycle:
//    sample discarded, fill_level=0;
//    with MEDIAN_WARMUP_PASS_EN, the next sample 42 is emitted raw as 42.

Source files
------------

// File: rtl/radar_filter_pkg.sv
// Shared types and constants for the radar noise-reducer window/median path.
package radar_filter_pkg;

    localparam int WIN_LEN = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } win_state_t;

    typedef logic signed [31:0] sample_t;

endpackage

// File: rtl/median_window_buffer_median_calculator.sv
// Combinational 5-input signed median: picks the first element with at most two
// strictly smaller peers and at least three peers (itself included) not larger.
module Median_Calculator
    import radar_filter_pkg::*;
(
    input  sample_t win_i [WIN_LEN],
    output sample_t median_o
);

    // Rank every element against the others and select the middle one.
    always_comb begin
        logic [2:0] lt_cnt;
        logic [2:0] le_cnt;
        logic       found;
        median_o = win_i[0];
        found    = 1'b0;
        for (int i = 0; i < WIN_LEN; i++) begin
            lt_cnt = 3'd0;
            le_cnt = 3'd0;
            for (int j = 0; j < WIN_LEN; j++) begin
                if (win_i[j] < win_i[i]) begin
                    lt_cnt = lt_cnt + 3'd1;
                end else begin
                    lt_cnt = lt_cnt;
                end
                if (win_i[j] <= win_i[i]) begin
                    le_cnt = le_cnt + 3'd1;
                end else begin
                    le_cnt = le_cnt;
                end
            end
            if (!found && (lt_cnt <= 3'd2) && (le_cnt >= 3'd3)) begin
                median_o = win_i[i];
                found    = 1'b1;
            end else begin
                found    = found;
            end
        end
    end

endmodule

// File: rtl/median_window_buffer.sv
// Sliding 5-sample window feeding Median_Calculator, with a registered valid/ready output.
// Optional MEDIAN_WARMUP_PASS_EN: warm-up samples are emitted raw instead of being dropped.
module median_window_buffer
    import radar_filter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [2:0]        fill_level
);

    logic signed [DATA_W-1:0] win_q [WIN_LEN];
    logic signed [DATA_W-1:0] win_d [WIN_LEN];
    logic signed [DATA_W-1:0] win_s [WIN_LEN];
    sample_t                  core_win_s [WIN_LEN];
    sample_t                  median_s;

    win_state_t               state_q, state_d;
    logic [2:0]               fill_q, fill_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;

    logic                     in_ready_s;
    logic                     acc_s;
    logic                     full_post_s;
    logic [2:0]               fill_post_s;

    assign in_ready_s = ~rst & ~flush & (~out_valid_q | out_ready);
    assign acc_s      = in_valid & in_ready_s;

    // Post-shift window: newest sample at index 0, sign-extended for the median core.
    always_comb begin
        win_s[0]      = $signed(in_data);
        core_win_s[0] = sample_t'($signed(in_data));
        for (int k = 1; k < WIN_LEN; k++) begin
            win_s[k]      = win_q[k-1];
            core_win_s[k] = sample_t'(win_q[k-1]);
        end
    end

    Median_Calculator u_median (
        .win_i    (core_win_s),
        .median_o (median_s)
    );

    assign fill_post_s = (fill_q >= 3'd4) ? 3'd5 : (fill_q + 3'd1);
    assign full_post_s = (state_q == FULL) || ((state_q == FILL) && (fill_q == 3'd4));

    // Next-state for window, fill count, FSM and output register.
    always_comb begin
        win_d       = win_q;
        fill_d      = fill_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (flush) begin
            for (int k = 0; k < WIN_LEN; k++) begin
                win_d[k] = '0;
            end
            fill_d  = 3'd0;
            state_d = EMPTY;
        end else if (acc_s) begin
            win_d  = win_s;
            fill_d = fill_post_s;
            case (state_q)
                EMPTY:   state_d = FILL;
                FILL:    state_d = (fill_q == 3'd4) ? FULL : FILL;
                FULL:    state_d = FULL;
                default: state_d = EMPTY;
            endcase
            // Frame end: median already taken from win_s, so the window can be wiped now.
            if (in_last) begin
                for (int k = 0; k < WIN_LEN; k++) begin
                    win_d[k] = '0;
                end
                fill_d  = 3'd0;
                state_d = EMPTY;
            end else begin
                state_d = state_d;
            end

            if (full_post_s) begin
                out_valid_d = 1'b1;
                out_data_d  = median_s[DATA_W-1:0];
                out_last_d  = in_last;
`ifdef MEDIAN_WARMUP_PASS_EN
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
                out_last_d  = in_last;
            end
`else
            end else begin
                out_data_d  = out_data_q;
            end
`endif
        end else begin
            fill_d = fill_q;
        end
    end

    // State, window and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < WIN_LEN; k++) begin
                win_q[k] <= '0;
            end
            state_q     <= EMPTY;
            fill_q      <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            win_q       <= win_d;
            state_q     <= state_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign fill_level = fill_q;

endmodule
